// File: rtl/sobel_kernel.sv
// Streaming 3x3 Sobel gradient-magnitude kernel: column-fed window, two arithmetic stages,
// saturated |Gx|+|Gy| output with per-pixel valid and an end-of-frame pulse.
module sobel_kernel #(
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       we_i,
    input  logic [7:0] row0_i,
    input  logic [7:0] row1_i,
    input  logic [7:0] row2_i,
    output logic [7:0] data_o,
    output logic       we_o,
    output logic       done_o
);

    localparam logic [11:0] COL_LAST = 12'(IMG_WIDTH - 1);
    localparam logic [11:0] ROW_LAST = 12'(IMG_HEIGHT - 1);

    logic [11:0] col, row;
    logic [7:0]  p00, p01, p02, p10, p11, p12, p20, p21, p22;
    logic        v1, last1, v2, last2;
    logic signed [10:0] gx, gy, gx_d, gy_d;
    logic [11:0] ax, ay, mag;
    logic        col_end, row_end, win_ok;

    assign col_end = (col == COL_LAST);
    assign row_end = (row == ROW_LAST);
    // Row gating also keeps windows from spanning a frame boundary.
    assign win_ok  = we_i && (col >= 12'd2) && (row >= 12'd2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (we_i) begin
            if (col_end) begin
                col <= '0;
                row <= row_end ? 12'd0 : row + 12'd1;
            end else begin
                col <= col + 12'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p00 <= '0; p01 <= '0; p02 <= '0;
            p10 <= '0; p11 <= '0; p12 <= '0;
            p20 <= '0; p21 <= '0; p22 <= '0;
        end else if (we_i) begin
            p00 <= p01; p01 <= p02; p02 <= row0_i;
            p10 <= p11; p11 <= p12; p12 <= row1_i;
            p20 <= p21; p21 <= p22; p22 <= row2_i;
        end
    end

    function automatic logic signed [10:0] ext(input logic [7:0] p);
        return $signed({3'b000, p});
    endfunction

    always_comb begin
        gx_d = (ext(p02) + (ext(p12) <<< 1) + ext(p22)) - (ext(p00) + (ext(p10) <<< 1) + ext(p20));
        gy_d = (ext(p20) + (ext(p21) <<< 1) + ext(p22)) - (ext(p00) + (ext(p01) <<< 1) + ext(p02));
    end

    always_comb begin
        ax  = {1'b0, (gx[10] ? -gx : gx)};
        ay  = {1'b0, (gy[10] ? -gy : gy)};
        mag = ax + ay;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1     <= 1'b0;
            last1  <= 1'b0;
            v2     <= 1'b0;
            last2  <= 1'b0;
            gx     <= '0;
            gy     <= '0;
            data_o <= '0;
            we_o   <= 1'b0;
            done_o <= 1'b0;
        end else begin
            v1     <= win_ok;
            last1  <= we_i && col_end && row_end;
            v2     <= v1;
            last2  <= v1 && last1;
            gx     <= gx_d;
            gy     <= gy_d;
            we_o   <= v2;
            done_o <= last2;
            if (v2) begin
                data_o <= (mag > 12'd255) ? 8'hFF : mag[7:0];
            end
        end
    end

endmodule

// File: tb/tb_sobel_kernel.sv
// Scoreboard bench for sobel_kernel on a 5x4 frame: driver pushes reference results,
// a negedge monitor pops and compares whenever we_o is seen.
module tb_sobel_kernel;

    localparam int W = 5;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       we_i;
    logic [7:0] row0_i, row1_i, row2_i;
    logic [7:0] data_o;
    logic       we_o, done_o;

    sobel_kernel #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk    (clk),
        .rst    (rst),
        .we_i   (we_i),
        .row0_i (row0_i),
        .row1_i (row1_i),
        .row2_i (row2_i),
        .data_o (data_o),
        .we_o   (we_o),
        .done_o (done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       done;
        int         cyc;
    } exp_t;

    exp_t       q[$];
    logic [7:0] img [0:H-1][0:W-1];
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    int         pulses = 0;
    int         dones = 0;
    logic [7:0] last_data = 8'd0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int px(input int r, input int c);
        return int'(img[r][c]);
    endfunction

    // Reference: window centred on (r-1, c-1), magnitude saturated at 255.
    function automatic logic [7:0] model(input int r, input int c);
        int gx, gy, m;
        gx = (px(r-2, c) + 2 * px(r-1, c) + px(r, c))
           - (px(r-2, c-2) + 2 * px(r-1, c-2) + px(r, c-2));
        gy = (px(r, c-2) + 2 * px(r, c-1) + px(r, c))
           - (px(r-2, c-2) + 2 * px(r-2, c-1) + px(r-2, c));
        m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        return (m > 255) ? 8'd255 : m[7:0];
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            check("reset_outputs", {data_o, we_o, done_o}, 0);
            last_data = 8'd0;
        end else if (we_o) begin
            exp_t e;
            pulses++;
            if (done_o) dones++;
            if (q.size() == 0) begin
                check("unexpected_we_o", 1, 0);
            end else begin
                e = q.pop_front();
                check("data_o", data_o, e.data);
                check("done_o", done_o, e.done);
                check("latency_cycle", cyc, e.cyc);
            end
            last_data = data_o;
        end else begin
            check("idle_hold", {done_o, data_o}, {1'b0, last_data});
        end
    end

    task automatic fill_const(input int v);
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 8'(v);
    endtask

    task automatic fill_edge();
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = (c < 2) ? 8'd0 : 8'd200;
    endtask

    task automatic fill_ramp();
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 8'(10 * r);
    endtask

    task automatic fill_rand();
        for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 8'($urandom);
    endtask

    task automatic send(input int ncols, input int gmin, input int gmax);
        for (int k = 0; k < ncols; k++) begin
            int r;
            int c;
            int g;
            exp_t e;
            r = k / W;
            c = k % W;
            row2_i = img[r][c];
            row1_i = (r >= 1) ? img[r-1][c] : 8'($urandom);
            row0_i = (r >= 2) ? img[r-2][c] : 8'($urandom);
            we_i = 1'b1;
            @(posedge clk);
            #1;
            we_i = 1'b0;
            if (r >= 2 && c >= 2) begin
                e.data = model(r, c);
                e.done = (r == H - 1) && (c == W - 1);
                e.cyc  = cyc + 2;
                q.push_back(e);
            end
            g = $urandom_range(gmax, gmin);
            repeat (g) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic drain(input string name, input int exp_pulses, input int exp_dones);
        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        check({name, "_drain"}, q.size(), 0);
        check({name, "_pulses"}, pulses, exp_pulses);
        check({name, "_dones"}, dones, exp_dones);
        q.delete();
        pulses = 0;
        dones = 0;
    endtask

    task automatic async_reset();
        #2 rst = 1'b1;
        q.delete();
        we_i = 1'b1;
        row0_i = 8'($urandom);
        row1_i = 8'($urandom);
        row2_i = 8'($urandom);
        repeat (2) @(posedge clk);
        #1;
        we_i = 1'b0;
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        we_i = 1'b0;
        row0_i = '0;
        row1_i = '0;
        row2_i = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        fill_const(100); send(W * H, 0, 0); drain("const", 6, 1);
        fill_edge();     send(W * H, 0, 0); drain("edge", 6, 1);
        fill_ramp();     send(W * H, 0, 0); drain("ramp", 6, 1);
        fill_edge();     send(W * H, 1, 3); drain("edge_gaps", 6, 1);

        fill_const(77);  send(7, 0, 0);  async_reset();
        fill_const(100); send(W * H, 0, 0); drain("after_abort7", 6, 1);

        fill_rand();     send(13, 0, 0); async_reset();
        fill_const(100); send(W * H, 0, 0); drain("after_abort_inflight", 6, 1);

        fill_const(50);  send(W * H, 0, 0);
        fill_const(150); send(W * H, 0, 0); drain("back_to_back", 12, 2);

        for (int f = 0; f < 4; f++) begin
            fill_rand();
            send(W * H, 0, 2);
        end
        drain("random", 24, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
